// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types and constants for the sprite line scheduler.
package sprite_pkg;

    localparam int unsigned NUM_SPRITES = 30;
    localparam int unsigned MAX_SLOTS   = 8;
    localparam int unsigned SPRITE_H    = 32;

    // Descriptor word layout; bits [31:26] carry nothing for this block.
    localparam int unsigned DESC_X_LSB  = 0;
    localparam int unsigned DESC_X_MSB  = 9;
    localparam int unsigned DESC_Y_LSB  = 10;
    localparam int unsigned DESC_Y_MSB  = 19;
    localparam int unsigned DESC_ID_LSB = 20;
    localparam int unsigned DESC_ID_MSB = 25;

    localparam logic [5:0]  SPRITE_ID_NONE = 6'd0;
    localparam logic [3:0]  MAX_COUNT      = 4'(MAX_SLOTS);
    localparam logic [4:0]  IDX_LAST       = 5'(NUM_SPRITES - 1);
    localparam logic [10:0] ROW_LAST       = 11'(SPRITE_H - 1);

    typedef struct packed {
        logic [9:0] x;
        logic [4:0] row;
        logic [5:0] id;
    } slot_t;

    typedef struct packed {
        slot_t [MAX_SLOTS-1:0] slots;
        logic [3:0]            count;
        logic                  overflow;
        logic                  late;
    } bank_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } scan_state_t;

    // Line minus sprite top in 11 bits; bit 10 set means the line is above the sprite.
    function automatic logic [10:0] line_diff(input logic [9:0] line, input logic [9:0] y);
        return {1'b0, line} - {1'b0, y};
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Descriptor fetch, line control and renderer read port of the scheduler.
interface sprite_line_scheduler_if;

    logic        line_start;
    logic [9:0]  line_num;
    logic [4:0]  desc_idx;
    logic [31:0] desc_data;
    logic [2:0]  slot_sel;
    logic        slot_valid;
    logic [9:0]  slot_x;
    logic [4:0]  slot_row;
    logic [5:0]  slot_id;
    logic [3:0]  active_count;
    logic        overflow;
    logic        late;
    logic        scan_busy;
    logic        scan_done;

    modport slave (
        input  line_start, line_num, desc_data, slot_sel,
        output desc_idx, slot_valid, slot_x, slot_row, slot_id,
               active_count, overflow, late, scan_busy, scan_done
    );

    modport master (
        output line_start, line_num, desc_data, slot_sel,
        input  desc_idx, slot_valid, slot_x, slot_row, slot_id,
               active_count, overflow, late, scan_busy, scan_done
    );

endinterface

// File: rtl/sprite_line_scheduler_slot_bank.sv
// Double-buffered slot lists: one bank is built by the scan, the other is read by the renderer.
module sprite_slot_bank
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       swap,
    input  logic       swap_late,
    input  logic       append,
    input  slot_t      append_slot,
    input  logic [2:0] slot_sel,
    output logic       slot_valid,
    output logic [9:0] slot_x,
    output logic [4:0] slot_row,
    output logic [5:0] slot_id,
    output logic [3:0] active_count,
    output logic       overflow,
    output logic       late
);

    bank_t bank [2];
    logic  act_sel;
    logic  build_sel;
    bank_t build_next;
    bank_t promoted;
    bank_t active;
    slot_t sel_slot;

    assign build_sel = ~act_sel;

    // Next value of the build bank after an append, and the bank as it will look once promoted.
    always_comb begin
        build_next = bank[build_sel];
        if (append) begin
            if (build_next.count < MAX_COUNT) begin
                build_next.slots[build_next.count[2:0]] = append_slot;
                build_next.count = build_next.count + 4'd1;
            end else begin
                build_next.overflow = 1'b1;
            end
        end
        promoted      = bank[build_sel];
        promoted.late = swap_late;
    end

    // Swap promotes the build bank and recycles the old active bank as a cleared build bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank[0] <= '0;
            bank[1] <= '0;
            act_sel <= 1'b0;
        end else if (swap) begin
            bank[act_sel]   <= '0;
            bank[build_sel] <= promoted;
            act_sel         <= build_sel;
        end else begin
            bank[build_sel] <= build_next;
        end
    end

    // Renderer read port; slots past the active count read as zero.
    always_comb begin
        active       = bank[act_sel];
        sel_slot     = active.slots[slot_sel];
        slot_valid   = ({1'b0, slot_sel} < active.count);
        slot_x       = slot_valid ? sel_slot.x   : '0;
        slot_row     = slot_valid ? sel_slot.row : '0;
        slot_id      = slot_valid ? sel_slot.id  : '0;
        active_count = active.count;
        overflow     = active.overflow;
        late         = active.late;
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite scan: walks all descriptors, keeps the first hits, hands the list over on line_start.
module sprite_line_scheduler
    import sprite_pkg::*;
(
    input  logic clk,
    input  logic reset,
    sprite_line_scheduler_if.slave bus
);

    scan_state_t state_q;
    scan_state_t state_d;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    logic [9:0]  line_q;
    logic        eval_q;
    logic        scan_busy;
    logic [10:0] diff;
    logic [5:0]  desc_id;
    logic        hit;
    logic        append;
    slot_t       desc_slot;
    logic        desc_unused;

    assign desc_unused = ^bus.desc_data[31:26];

    // Scan state, index counter, latched line and the descriptor-valid pipeline flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            eval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (bus.line_start) begin
                line_q <= bus.line_num;
            end
            // A read issued in the swap cycle belongs to the aborted scan and is never evaluated.
            eval_q  <= (state_q == S_ISSUE) && !bus.line_start;
        end
    end

    // Next-state and scan control outputs; line_start always restarts the scan at index 0.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        bus.desc_idx  = '0;
        scan_busy     = 1'b0;
        bus.scan_done = 1'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_ISSUE: begin
                bus.desc_idx = idx_q;
                scan_busy    = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_DRAIN: begin
                scan_busy = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                bus.scan_done = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.line_start) begin
            state_d = S_ISSUE;
            idx_d   = '0;
        end
    end

    assign bus.scan_busy = scan_busy;

    // Vertical hit test on the descriptor returned for the previous cycle's index.
    always_comb begin
        diff          = line_diff(line_q, bus.desc_data[DESC_Y_MSB:DESC_Y_LSB]);
        desc_id       = bus.desc_data[DESC_ID_MSB:DESC_ID_LSB];
        desc_slot.x   = bus.desc_data[DESC_X_MSB:DESC_X_LSB];
        desc_slot.row = diff[4:0];
        desc_slot.id  = desc_id;
        hit           = (desc_id != SPRITE_ID_NONE) && !diff[10] && (diff <= ROW_LAST);
        append        = eval_q && hit && !bus.line_start;
    end

    sprite_slot_bank u_bank (
        .clk          (clk),
        .reset        (reset),
        .swap         (bus.line_start),
        .swap_late    (scan_busy),
        .append       (append),
        .append_slot  (desc_slot),
        .slot_sel     (bus.slot_sel),
        .slot_valid   (bus.slot_valid),
        .slot_x       (bus.slot_x),
        .slot_row     (bus.slot_row),
        .slot_id      (bus.slot_id),
        .active_count (bus.active_count),
        .overflow     (bus.overflow),
        .late         (bus.late)
    );

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a registered descriptor-file model.
module tb_sprite_line_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] desc_mem [30];

    sprite_line_scheduler_if bus();

    sprite_line_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Descriptor register file: data for an index appears one cycle after it is presented.
    always @(posedge clk) begin
        bus.desc_data <= desc_mem[bus.desc_idx];
    end

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] id;
        logic [9:0] line;
        int         exp_count;
        logic [4:0] exp_row;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_desc();
        for (int i = 0; i < 30; i++) desc_mem[i] = 32'd0;
    endtask

    function automatic logic [31:0] mk_desc(input logic [9:0] x, input logic [9:0] y, input logic [5:0] id);
        return {6'd0, id, y, x};
    endfunction

    // Pulse line_start in one cycle; returns at the negedge of the following cycle (cycle 1).
    task automatic start_line(input logic [9:0] n);
        @(negedge clk);
        bus.line_start = 1'b1;
        bus.line_num   = n;
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask

    // Called at cycle 1 of a scan; returns in the scan_done cycle with its cycle number.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.scan_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("scan_done_seen", {31'd0, bus.scan_done}, 32'd1);
    endtask

    task automatic check_slot(input string tag, input logic [2:0] sel, input logic [9:0] x,
                              input logic [4:0] row, input logic [5:0] id);
        bus.slot_sel = sel;
        #1;
        check({tag, "_valid"}, {31'd0, bus.slot_valid}, 32'd1);
        check({tag, "_x"},     {22'd0, bus.slot_x},     {22'd0, x});
        check({tag, "_row"},   {27'd0, bus.slot_row},   {27'd0, row});
        check({tag, "_id"},    {26'd0, bus.slot_id},    {26'd0, id});
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic ovf, input logic lt);
        check({tag, "_count"},    {28'd0, bus.active_count}, 32'(cnt));
        check({tag, "_overflow"}, {31'd0, bus.overflow},     {31'd0, ovf});
        check({tag, "_late"},     {31'd0, bus.late},         {31'd0, lt});
    endtask

    int c;
    int extra;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        clear_desc();
        reset          = 1'b1;
        bus.line_start = 1'b0;
        bus.line_num   = '0;
        bus.slot_sel   = '0;

        vecs[0] = '{x: 10'd200,  y: 10'd100,  id: 6'd5,  line: 10'd110,  exp_count: 1, exp_row: 5'd10};
        vecs[1] = '{x: 10'd200,  y: 10'd100,  id: 6'd5,  line: 10'd99,   exp_count: 0, exp_row: 5'd0};
        vecs[2] = '{x: 10'd201,  y: 10'd100,  id: 6'd6,  line: 10'd100,  exp_count: 1, exp_row: 5'd0};
        vecs[3] = '{x: 10'd202,  y: 10'd100,  id: 6'd7,  line: 10'd131,  exp_count: 1, exp_row: 5'd31};
        vecs[4] = '{x: 10'd203,  y: 10'd100,  id: 6'd8,  line: 10'd132,  exp_count: 0, exp_row: 5'd0};
        vecs[5] = '{x: 10'd204,  y: 10'd1000, id: 6'd9,  line: 10'd5,    exp_count: 0, exp_row: 5'd0};
        vecs[6] = '{x: 10'd205,  y: 10'd100,  id: 6'd0,  line: 10'd110,  exp_count: 0, exp_row: 5'd0};
        vecs[7] = '{x: 10'd0,    y: 10'd0,    id: 6'd63, line: 10'd31,   exp_count: 1, exp_row: 5'd31};
        vecs[8] = '{x: 10'd1023, y: 10'd992,  id: 6'd1,  line: 10'd1023, exp_count: 1, exp_row: 5'd31};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_desc_idx",  {27'd0, bus.desc_idx},  32'd0);
        check("rst_scan_busy", {31'd0, bus.scan_busy}, 32'd0);
        check("rst_scan_done", {31'd0, bus.scan_done}, 32'd0);
        check("rst_slot_valid",{31'd0, bus.slot_valid},32'd0);
        check_flags("rst", 0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Single sprite: exact issue sequence and done timing
        desc_mem[3] = mk_desc(10'd200, 10'd100, 6'd5);
        start_line(10'd110);
        for (int k = 0; k < 30; k++) begin
            check("seq_desc_idx", {27'd0, bus.desc_idx}, 32'(k));
            check("seq_busy",     {31'd0, bus.scan_busy}, 32'd1);
            @(negedge clk);
        end
        check("drain_busy", {31'd0, bus.scan_busy}, 32'd1);
        check("drain_done", {31'd0, bus.scan_done}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, bus.scan_done}, 32'd1);
        check("done_busy",  {31'd0, bus.scan_busy}, 32'd0);
        start_line(10'd0);
        check_flags("single", 1, 1'b0, 1'b0);
        check_slot("single_s0", 3'd0, 10'd200, 5'd10, 6'd5);
        bus.slot_sel = 3'd1;
        #1;
        check("single_s1_valid", {31'd0, bus.slot_valid}, 32'd0);
        check("single_s1_x",     {22'd0, bus.slot_x},     32'd0);
        wait_done(c);

        // Table: single sprite at index 3 against several lines
        for (int v = 0; v < 9; v++) begin
            clear_desc();
            desc_mem[3] = mk_desc(vecs[v].x, vecs[v].y, vecs[v].id);
            start_line(vecs[v].line);
            wait_done(c);
            check("vec_done_cycle", 32'(c), 32'd32);
            start_line(10'd0);
            wait_done(c);
            check_flags("vec", vecs[v].exp_count, 1'b0, 1'b0);
            if (vecs[v].exp_count != 0) begin
                check_slot("vec_s0", 3'd0, vecs[v].x, vecs[v].exp_row, vecs[v].id);
            end else begin
                bus.slot_sel = 3'd0;
                #1;
                check("vec_s0_valid", {31'd0, bus.slot_valid}, 32'd0);
                check("vec_s0_x",     {22'd0, bus.slot_x},     32'd0);
            end
        end

        // Overflow: ten hits at indices 2..11, disabled hitting sprite at 12
        clear_desc();
        for (int k = 2; k < 12; k++) desc_mem[k] = mk_desc(10'(k * 10), 10'd50, 6'(k + 1));
        desc_mem[12] = mk_desc(10'd999, 10'd50, 6'd0);
        start_line(10'd60);
        wait_done(c);
        start_line(10'd0);
        check_flags("ovf", 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_slot("ovf_slot", 3'(i), 10'((i + 2) * 10), 5'd10, 6'(i + 3));
        end
        wait_done(c);

        // Abort at cycle 15: only indices <= 12 survive
        clear_desc();
        desc_mem[1]  = mk_desc(10'd11,  10'd50, 6'd2);
        desc_mem[5]  = mk_desc(10'd51,  10'd50, 6'd6);
        desc_mem[12] = mk_desc(10'd121, 10'd50, 6'd13);
        desc_mem[13] = mk_desc(10'd131, 10'd50, 6'd14);
        desc_mem[14] = mk_desc(10'd141, 10'd50, 6'd15);
        desc_mem[20] = mk_desc(10'd201, 10'd50, 6'd21);
        start_line(10'd60);
        for (int k = 1; k < 15; k++) begin
            if (bus.scan_done) check("abort_early_done", {31'd0, bus.scan_done}, 32'd0);
            @(negedge clk);
        end
        bus.line_start = 1'b1;
        bus.line_num   = 10'd70;
        @(negedge clk);
        bus.line_start = 1'b0;
        check("abort_restart_idx", {27'd0, bus.desc_idx}, 32'd0);
        check("abort_restart_busy", {31'd0, bus.scan_busy}, 32'd1);
        check_flags("abort", 3, 1'b0, 1'b1);
        check_slot("abort_s0", 3'd0, 10'd11,  5'd10, 6'd2);
        check_slot("abort_s1", 3'd1, 10'd51,  5'd10, 6'd6);
        check_slot("abort_s2", 3'd2, 10'd121, 5'd10, 6'd13);
        wait_done(c);
        check("abort_done_cycle", 32'(c), 32'd32);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.scan_done) extra++;
        end
        check("abort_extra_done", 32'(extra), 32'd0);
        start_line(10'd0);
        check_flags("after_abort", 6, 1'b0, 1'b0);
        check_slot("after_abort_s0", 3'd0, 10'd11, 5'd20, 6'd2);
        wait_done(c);

        // Reset in cycle 10 of a scan
        start_line(10'd60);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_desc_idx", {27'd0, bus.desc_idx},  32'd0);
        check("mid_rst_busy",     {31'd0, bus.scan_busy}, 32'd0);
        check("mid_rst_done",     {31'd0, bus.scan_done}, 32'd0);
        check("mid_rst_valid",    {31'd0, bus.slot_valid},32'd0);
        check_flags("mid_rst", 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.scan_done) extra++;
        end
        check("mid_rst_no_done", 32'(extra), 32'd0);
        start_line(10'd60);
        wait_done(c);
        check("post_rst_done_cycle", 32'(c), 32'd32);
        start_line(10'd0);
        check_flags("post_rst", 6, 1'b0, 1'b0);
        check_slot("post_rst_s5", 3'd5, 10'd201, 5'd10, 6'd21);
        wait_done(c);

        // Back-to-back lines every 33 cycles with one moving sprite
        clear_desc();
        for (int i = 0; i < 5; i++) begin
            desc_mem[7] = mk_desc(10'(100 + i), 10'(190 - i), 6'd9);
            start_line(10'(200 + i));
            if (i > 0) begin
                check_flags("move", 1, 1'b0, 1'b0);
                check_slot("move_s0", 3'd0, 10'(100 + i - 1), 5'(10 + 2 * (i - 1)), 6'd9);
            end
            wait_done(c);
            check("move_done_cycle", 32'(c), 32'd32);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler between the 30-entry sprite descriptor register file and the sprite pixel renderer.
- On each line_start it scans all descriptors in index order. Up to MAX_SLOTS sprites that intersect the requested line go into a build list.
- The list built during the previous line is presented to the renderer as the active list. Two banks, swapped on line_start.

Parameters:
- NUM_SPRITES, 30, number of descriptor registers scanned (index width 5).
- MAX_SLOTS, 8, maximum sprites per line.
- SPRITE_H, 32, sprite height in lines (ROM image 32x32, 10-bit ROM address).

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  asynchronous, active-high reset.
- line_start  in  1  single-cycle pulse: start preparing line line_num and swap banks.
- line_num  in  10  line to prepare, sampled when line_start=1.
- desc_idx  out  5  descriptor read index; desc_data is valid one cycle later.
- desc_data  in  32  descriptor: [9:0]=x, [19:10]=y, [25:20]=id, [31:26] ignored. id=0 means disabled.
- slot_sel  in  3  active-list slot to read (combinational).
- slot_valid  out  1  slot_sel < active_count.
- slot_x  out  10  x of selected active slot.
- slot_row  out  5  line_num - y of selected slot (ROM row).
- slot_id  out  6  sprite id (ROM select) of selected slot.
- active_count  out  4  number of valid active slots, 0..MAX_SLOTS.
- overflow  out  1  active list dropped at least one hit.
- late  out  1  active list is partial; its scan was cut short by line_start.
- scan_busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse when a scan completes normally.

Behaviour:

Reset (async):
- State IDLE.
- Both banks: count=0, overflow=0, late=0, slots zero.
- Active bank select=0.
- All outputs 0: desc_idx=0, scan_busy=0, scan_done=0, slot_valid=0.

States:
- IDLE: desc_idx=0, scan_busy=0. line_start -> ISSUE.
- ISSUE: desc_idx counts 0..NUM_SPRITES-1, one per cycle. After index NUM_SPRITES-1 -> DRAIN.
- DRAIN: one cycle to evaluate the last descriptor. Then scan_done=1 for one cycle -> IDLE.

Timing, with line_start in cycle 0:
- Bank swap and line_num latch take effect at the end of cycle 0.
- Build bank count, overflow and late are cleared at the end of cycle 0.
- desc_idx=k in cycle k+1.
- Descriptor k is evaluated in cycle k+2 and written at the end of that cycle.
- scan_done is asserted in cycle NUM_SPRITES+2 (cycle 32 for the defaults).
- scan_busy=1 in cycles 1..NUM_SPRITES+1.

Hit rule:
- id != 0, and diff = {1'b0,line_num} - {1'b0,y} computed in 11 bits satisfies 0 <= diff <= SPRITE_H-1.
- No vertical wrap: y=1000 never hits line 5.
- slot_row = diff[4:0].

Priority and overflow:
- Lower descriptor index wins. Slots fill 0,1,2,... in scan order.
- A hit when count == MAX_SLOTS is dropped and sets the build-bank overflow. count saturates at MAX_SLOTS.

Bank swap:
- On line_start the build bank becomes active: active_count, overflow and late follow it.
- The previous active bank becomes build bank and is cleared.
- Active-bank outputs change only on a swap.
- slot_* outputs for slot_sel >= active_count are 0.

line_start while scan_busy=1 (ISSUE or DRAIN):
- The scan aborts.
- The partial build bank becomes active with late=1.
- The scan restarts at index 0 for the new line_num.
- No scan_done is generated for the aborted scan.
- An evaluation of the aborted scan that is in flight in the swap cycle is discarded.

line_start in the scan_done cycle: a normal swap; late=0.

Reset mid-scan: immediate return to IDLE with all reset values. No scan_done.

Decomposition:
- Package sprite_pkg holds:
  - descriptor field LSB/MSB constants, SPRITE_ID_NONE=0, SPRITE_H;
  - typedef slot_t {x[9:0], row[4:0], id[5:0]};
  - typedef bank_t {slot_t slots[MAX_SLOTS]; count[3:0]; overflow; late}.
- Sub-module sprite_slot_bank holds the two banks with swap, clear, append and read-port logic. The FSM, index counter and hit compare stay in the top.

Test Plan:
1. Single sprite desc[3]={x=200,y=100,id=5}, line_start line_num=110, wait scan_done, then line_start -> active_count=1, slot0={x=200,row=10,id=5}. desc_idx sequence 0..29 in cycles 1..30; scan_done in cycle 32.
2. Vertical boundaries, y=100: line 99 -> count 0; line 100 -> row 0; line 131 -> row 31; line 132 -> count 0. y=1000 with line 5 -> count 0.
3. Ten enabled sprites at indices 2..11, all hitting -> slots hold indices 2..9 in order, active_count=8, overflow=1, late=0. Sprite with id=0 at a hitting y -> ignored.
4. line_start again at cycle 15 of a scan -> active list holds only hits from indices <= 12, late=1. New scan restarts at desc_idx=0 in the next cycle. Only one scan_done follows, 32 cycles after the second line_start.
5. Assert reset at cycle 10 of a scan -> outputs immediately zero and state IDLE. No scan_done. Next line_start performs a clean full scan.
6. Back-to-back line_start pulses every 33 cycles for 4 lines with one moving sprite -> each active list reflects the previous line_num. overflow and late stay 0.
